// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Two-requester frame scheduler in front of a shared UART byte transmitter.
// A granted requester's two BCD digits are captured, then sent as the frame
// ID ('A' or 'B'), the tens digit, the units digit, and an optional line
// feed. Out-of-range digits (10..15) are sent as '?'. When both requesters
// are waiting, the one not served last goes first.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   req_a, req_b     frame requests (level, held until the matching grant)
//   a_bcd1, a_bcd0   requester A tens / units digit
//   b_bcd1, b_bcd0   requester B tens / units digit
//   gnt_a, gnt_b     one-cycle pulse: that requester's digits were captured
//   busy             a frame is in progress (any state but IDLE)
//   tx_data          byte offered to the transmitter
//   tx_valid         tx_data is valid
//   tx_ready         transmitter takes tx_data at this edge
module uart_tx_sched #(
  parameter int LF_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [3:0] a_bcd1,
  input  logic [3:0] a_bcd0,
  input  logic       req_b,
  input  logic [3:0] b_bcd1,
  input  logic [3:0] b_bcd0,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND_ID = 3'd1;
  localparam logic [2:0] SEND_HI = 3'd2;
  localparam logic [2:0] SEND_LO = 3'd3;
  localparam logic [2:0] SEND_LF = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       last_b;   // last served requester: 1 = B, 0 = A
  logic       cap_b;    // requester of the frame in progress
  logic [3:0] cap_hi;
  logic [3:0] cap_lo;
  logic       win_a;
  logic       win_b;
  logic       xfer;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    if (d <= 4'd9) ascii_digit = 8'h30 + {4'h0, d};
    else           ascii_digit = 8'h3F;
  endfunction

  // A wins when alone, or on a tie when B was served last.
  assign win_a = req_a & (~req_b | last_b);
  assign win_b = req_b & ~win_a;

  // Valid comes from state alone, so an async reset drops it at once.
  assign tx_valid = (state != IDLE);
  assign busy     = (state != IDLE);
  assign xfer     = tx_valid & tx_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_a | win_b) state_nxt = SEND_ID;
      SEND_ID: if (xfer) state_nxt = SEND_HI;
      SEND_HI: if (xfer) state_nxt = SEND_LO;
      SEND_LO: if (xfer) state_nxt = (LF_EN != 0) ? SEND_LF : IDLE;
      SEND_LF: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured digits only change in IDLE, so the offered byte is stable
  // for the whole time it waits on tx_ready.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      SEND_ID: tx_data = cap_b ? 8'h42 : 8'h41;
      SEND_HI: tx_data = ascii_digit(cap_hi);
      SEND_LO: tx_data = ascii_digit(cap_lo);
      SEND_LF: tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
      cap_b  <= 1'b0;
      cap_hi <= 4'h0;
      cap_lo <= 4'h0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_a <= (state == IDLE) & win_a;
      gnt_b <= (state == IDLE) & win_b;
      if ((state == IDLE) && (win_a || win_b)) begin
        last_b <= win_b;
        cap_b  <= win_b;
        cap_hi <= win_b ? b_bcd1 : a_bcd1;
        cap_lo <= win_b ? b_bcd0 : a_bcd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: one instance with the line feed, one without.
// Expected bytes are queued when a frame is requested and checked as the
// transmitter accepts them.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, tx_ready = 1'b0;
  logic [3:0] a_bcd1 = 4'h0, a_bcd0 = 4'h0, b_bcd1 = 4'h0, b_bcd0 = 4'h0;
  logic       gnt_a1, gnt_b1, busy1, txv1;
  logic [7:0] txd1;

  logic       req_b_s = 1'b0, tx_ready_s = 1'b0;
  logic [3:0] b_bcd1_s = 4'h0, b_bcd0_s = 4'h0;
  logic       gnt_a0, gnt_b0, busy0, txv0;
  logic [7:0] txd0;

  logic [8:0] q1[$];
  logic [8:0] q0[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       pv1 = 1'b0, pv0 = 1'b0;
  logic [8:0] exp1, exp0;
  logic       ga, gb;

  uart_tx_sched #(.LF_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a_bcd1(a_bcd1), .a_bcd0(a_bcd0),
    .req_b(req_b), .b_bcd1(b_bcd1), .b_bcd0(b_bcd0),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .busy(busy1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready)
  );

  uart_tx_sched #(.LF_EN(0)) u_dut_nolf (
    .clk(clk), .rst(rst),
    .req_a(1'b0), .a_bcd1(4'h0), .a_bcd0(4'h0),
    .req_b(req_b_s), .b_bcd1(b_bcd1_s), .b_bcd0(b_bcd0_s),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .busy(busy0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input bit sel, input logic [7:0] c0, c1, c2, c3, input int n);
    logic [7:0] c[4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < n; i++) begin
      if (sel) q0.push_back({1'b0, c[i]});
      else     q1.push_back({1'b0, c[i]});
    end
  endtask

  task automatic wait_gnt(input bit sel, output logic oa, output logic ob);
    oa = 1'b0; ob = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      oa = sel ? gnt_a0 : gnt_a1;
      ob = sel ? gnt_b0 : gnt_b1;
      if (oa || ob) break;
    end
    if (!(oa || ob)) chk("gnt_timeout", {31'd0, oa | ob}, 32'd1);
  endtask

  task automatic wait_idle(input bit sel);
    logic b;
    int   qs;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      b  = sel ? busy0 : busy1;
      qs = sel ? q0.size() : q1.size();
      if (!b && qs == 0) break;
    end
    chk(sel ? "idle_busy0" : "idle_busy1", {31'd0, b}, 32'd0);
    chk(sel ? "idle_q0" : "idle_q1", qs, 32'd0);
  endtask

  // Transfers are sampled mid-cycle; the byte moves at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (gnt_a1 | gnt_b1) begin
        chk("gap1", {31'd0, pv1}, 32'd0);
        chk("id_valid1", {31'd0, txv1}, 32'd1);
      end
      if (txv1) begin
        exp1 = (q1.size() == 0) ? 9'h1FF : q1[0];
        if (tx_ready) begin
          chk("byte1", {24'd0, txd1}, {23'd0, exp1});
          if (q1.size() != 0) void'(q1.pop_front());
        end else chk("hold1", {24'd0, txd1}, {23'd0, exp1});
      end
    end
    pv1 = txv1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (gnt_a0 | gnt_b0) chk("gap0", {31'd0, pv0}, 32'd0);
      if (txv0) begin
        exp0 = (q0.size() == 0) ? 9'h1FF : q0[0];
        if (tx_ready_s) begin
          chk("byte0", {24'd0, txd0}, {23'd0, exp0});
          if (q0.size() != 0) void'(q0.pop_front());
        end else chk("hold0", {24'd0, txd0}, {23'd0, exp0});
      end
    end
    pv0 = txv0;
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {31'd0, txv1}, 32'd0);
    chk("rst_data", {24'd0, txd1}, 32'd0);
    chk("rst_gnt_a", {31'd0, gnt_a1}, 32'd0);
    chk("rst_gnt_b", {31'd0, gnt_b1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic A frame with line feed
    tx_ready = 1'b1; a_bcd1 = 4'd0; a_bcd0 = 4'd7;
    push_frame(0, 8'h41, 8'h30, 8'h37, 8'h0A, 4);
    req_a = 1'b1;
    wait_gnt(0, ga, gb);
    chk("t1_gnt_a", {31'd0, ga}, 32'd1);
    chk("t1_gnt_b", {31'd0, gb}, 32'd0);
    req_a = 1'b0;
    @(posedge clk); #1;
    chk("t1_gnt_pulse", {31'd0, gnt_a1}, 32'd0);
    wait_idle(0);

    // Reset restores A priority; both held -> strict alternation
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    a_bcd1 = 4'd1; a_bcd0 = 4'd5; b_bcd1 = 4'd9; b_bcd0 = 4'd9;
    for (int i = 0; i < 2; i++) begin
      push_frame(0, 8'h41, 8'h31, 8'h35, 8'h0A, 4);
      push_frame(0, 8'h42, 8'h39, 8'h39, 8'h0A, 4);
    end
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(0, ga, gb);
      chk("rr_a", {31'd0, ga}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_b", {31'd0, gb}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle(0);

    // Same requester held alone is granted again
    push_frame(0, 8'h42, 8'h39, 8'h39, 8'h0A, 4);
    push_frame(0, 8'h42, 8'h39, 8'h39, 8'h0A, 4);
    req_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_gnt(0, ga, gb);
      chk("regrant_b", {31'd0, gb}, 32'd1);
    end
    req_b = 1'b0;
    wait_idle(0);

    // Stall during SEND_HI
    a_bcd1 = 4'd3; a_bcd0 = 4'd4;
    push_frame(0, 8'h41, 8'h33, 8'h34, 8'h0A, 4);
    req_a = 1'b1;
    wait_gnt(0, ga, gb);
    req_a = 1'b0;
    @(posedge clk); #1 tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_valid", {31'd0, txv1}, 32'd1);
    chk("stall_data", {24'd0, txd1}, 32'h33);
    tx_ready = 1'b1;
    wait_idle(0);

    // Digit change after grant does not reach the frame
    a_bcd1 = 4'd0; a_bcd0 = 4'd7;
    push_frame(0, 8'h41, 8'h30, 8'h37, 8'h0A, 4);
    req_a = 1'b1;
    wait_gnt(0, ga, gb);
    req_a = 1'b0;
    @(posedge clk); #1 a_bcd0 = 4'd5; a_bcd1 = 4'd9;
    wait_idle(0);

    // Reset in SEND_LO abandons the frame
    tx_ready = 1'b0; a_bcd1 = 4'd2; a_bcd0 = 4'd8;
    push_frame(0, 8'h41, 8'h32, 8'h00, 8'h00, 2);
    req_a = 1'b1;
    wait_gnt(0, ga, gb);
    req_a = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 tx_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, txv1}, 32'd0);
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    chk("arst_data", {24'd0, txd1}, 32'd0);
    chk("arst_q", q1.size(), 32'd0);
    tx_ready = 1'b1; b_bcd1 = 4'd6; b_bcd0 = 4'd1; req_b = 1'b1;
    push_frame(0, 8'h42, 8'h36, 8'h31, 8'h0A, 4);
    @(posedge clk); #1 rst = 1'b1;
    wait_gnt(0, ga, gb);
    chk("arst_gnt_b", {31'd0, gb}, 32'd1);
    req_b = 1'b0;
    wait_idle(0);

    // No line feed instance, out-of-range digits
    tx_ready_s = 1'b1; b_bcd1_s = 4'd12; b_bcd0_s = 4'd4;
    push_frame(1, 8'h42, 8'h3F, 8'h34, 8'h00, 3);
    req_b_s = 1'b1;
    wait_gnt(1, ga, gb);
    chk("nolf_gnt_b", {31'd0, gb}, 32'd1);
    req_b_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("nolf_idle", {31'd0, busy0}, 32'd0);
    b_bcd1_s = 4'd9; b_bcd0_s = 4'd10;
    push_frame(1, 8'h42, 8'h39, 8'h3F, 8'h00, 3);
    req_b_s = 1'b1;
    wait_gnt(1, ga, gb);
    req_b_s = 1'b0;
    wait_idle(1);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter LF_EN, default 1, meaning: 1 = append line-feed byte 0x0A to each frame; 0 = 3-byte frame.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-004 req_a  input  1  requester A frame request, level; held until gnt_a.
REQ-005 a_bcd1  input  4  requester A tens digit.
REQ-006 a_bcd0  input  4  requester A units digit.
REQ-007 req_b  input  1  requester B frame request, level; held until gnt_b.
REQ-008 b_bcd1  input  4  requester B tens digit.
REQ-009 b_bcd0  input  4  requester B units digit.
REQ-010 gnt_a  output  1  one-cycle pulse: A's digits captured.
REQ-011 gnt_b  output  1  one-cycle pulse: B's digits captured.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tx_data  output  8  byte offered to the shared UART byte transmitter.
REQ-014 tx_valid  output  1  tx_data is valid.
REQ-015 tx_ready  input  1  transmitter accepts tx_data at this edge.

Function
REQ-016 States SHALL be IDLE, SEND_ID, SEND_HI, SEND_LO and SEND_LF; SEND_LF SHALL be used only when LF_EN=1.
REQ-017 Byte transfer SHALL occur at a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL stay stable while tx_valid=1 and no transfer has occurred.
REQ-018 In IDLE with any request high at edge k, the block SHALL capture the winner's two digits and set last_served to the winner at edge k.
REQ-019 After a grant at edge k, the matching gnt SHALL be high for exactly the cycle after edge k, and the state SHALL be SEND_ID with tx_valid=1.
REQ-020 Arbitration: one request high -> grant it; both high -> grant the requester not equal to last_served (round-robin).
REQ-021 SEND_ID SHALL offer 0x41 ('A') for A and 0x42 ('B') for B; SEND_HI SHALL offer ASCII of captured bcd1; SEND_LO SHALL offer ASCII of captured bcd0.
REQ-022 Digit d in 0..9 SHALL map to 0x30+d; d in 10..15 SHALL map to 0x3F ('?').
REQ-023 Each transfer SHALL advance SEND_ID->SEND_HI->SEND_LO->(SEND_LF if LF_EN)->IDLE; with no transfer the state SHALL hold.
REQ-024 The edge carrying the final transfer SHALL return to IDLE with tx_valid=0, and tx_valid SHALL stay 0 for at least one cycle before the next frame.
REQ-025 Requests SHALL be ignored while busy=1; a request still high on return to IDLE SHALL be arbitrated normally, including a re-grant of the same requester.
REQ-026 Input digit changes after the grant SHALL NOT affect the frame in progress.
REQ-027 tx_valid SHALL depend only on state and SHALL NOT depend combinationally on tx_ready.

Reset
REQ-028 While rst=0: state=IDLE, tx_valid=0, tx_data=0x00, gnt_a=0, gnt_b=0, busy=0, captured digits=0, last_served=B, so A wins the first tie.
REQ-029 rst asserted mid-frame SHALL abandon the frame, drop tx_valid without waiting for a clock edge, and SHALL NOT resume the frame after release.

Verification
REQ-030 Reset release, req_a=1, a_bcd1=0, a_bcd0=7, tx_ready=1, LF_EN=1 -> gnt_a pulse, then bytes 0x41,0x30,0x37,0x0A on consecutive edges, then busy=0.
REQ-031 req_a=req_b=1 held; A digits 1,5; B digits 9,9 -> frames A"15\n", B"99\n", then A again, strictly alternating, at least one idle cycle between frames.
REQ-032 tx_ready=0 for 5 cycles during SEND_HI of a_bcd1=3 -> tx_data stays 0x33 with tx_valid=1, no state change, byte sent once after tx_ready rises.
REQ-033 b_bcd1=12, b_bcd0=4, LF_EN=0 -> bytes 0x42,0x3F,0x34, then IDLE, no 0x0A.
REQ-034 Change a_bcd0 from 7 to 5 one cycle after gnt_a -> frame still carries 0x37.
REQ-035 rst pulsed low during SEND_LO -> tx_valid=0 immediately, busy=0; after release with req_b=1 only, a full B frame is sent from SEND_ID.
